// File: rtl/tinyrisc_pkg.sv
// Shared TinyRISC datapath types: skid-buffer occupancy state and select-width helper.
package tinyrisc_pkg;

  // Occupancy of the two-entry output buffer (main register + skid register).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Binary select width for an N-input selector; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_skid_if.sv
// Handshake/data bundle for the mux_n_skid stage.
interface mux_n_skid_if
  import tinyrisc_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned N = 4
);

  localparam int unsigned SELW = sel_width(N);

  logic [N*W-1:0]  in_data;
  logic [SELW-1:0] sel;
  logic [N-1:0]    sel_oh;
  logic            en;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;

  // Upstream/downstream environment side.
  modport master (
    output in_data, sel, sel_oh, en, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Stage side.
  modport slave (
    input  in_data, sel, sel_oh, en, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/mux_n.sv
// Combinational N-input selector with binary or one-hot select and enable gating.
module mux_n
  import tinyrisc_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned N      = 4,
  parameter bit          ONEHOT = 1'b0,
  localparam int unsigned SELW  = sel_width(N)
) (
  input  logic [N*W-1:0]  in_data,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    sel_oh,
  input  logic            en,
  output logic [W-1:0]    m_c
);

  if (ONEHOT) begin : g_onehot
    logic found;
    logic unused_sel;
    assign unused_sel = ^sel;

    // Lowest set bit of sel_oh wins; no bit set (or en low) yields zero.
    always_comb begin
      m_c   = '0;
      found = 1'b0;
      if (en) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (!found && sel_oh[i]) begin
            m_c   = in_data[i*W +: W];
            found = 1'b1;
          end
        end
      end
    end
  end else begin : g_binary
    logic unused_sel_oh;
    assign unused_sel_oh = ^sel_oh;

    // Indexed pick; codes at or above N match nothing and give zero.
    always_comb begin
      m_c = '0;
      if (en) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (SELW'(i) == sel) begin
            m_c = in_data[i*W +: W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/mux_n_skid.sv
// N:1 select stage feeding a two-entry skid buffer with valid/ready on both sides.
module mux_n_skid
  import tinyrisc_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned N      = 4,
  parameter bit          ONEHOT = 1'b0
) (
  input logic         clk,
  input logic         rst,
  mux_n_skid_if.slave bus
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  logic [W-1:0] m_c;
  logic         in_fire_c;
  logic         out_fire_c;

  mux_n #(
    .W      (W),
    .N      (N),
    .ONEHOT (ONEHOT)
  ) u_mux (
    .in_data (bus.in_data),
    .sel     (bus.sel),
    .sel_oh  (bus.sel_oh),
    .en      (bus.en),
    .m_c     (m_c)
  );

  // Both handshakes qualify only on registered flags, so in_ready never sees out_ready.
  assign in_fire_c  = bus.in_valid && in_ready_q;
  assign out_fire_c = out_valid_q && bus.out_ready;

  // State and data registers; reset empties the buffer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Occupancy transitions; flush overrides any same-cycle accept.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire_c) state_d = ONE;
        ONE: begin
          if (in_fire_c && !out_fire_c) begin
            state_d = FULL;
          end else if (!in_fire_c && out_fire_c) begin
            state_d = EMPTY;
          end
        end
        FULL:    if (out_fire_c) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Data movement and next handshake flags; registers hold unless loaded or shifted.
  always_comb begin
    main_d      = main_q;
    skid_d      = skid_q;
    if (bus.flush) begin
      main_d = '0;
      skid_d = '0;
    end else begin
      case (state_q)
        EMPTY: if (in_fire_c) main_d = m_c;
        ONE: begin
          if (in_fire_c && out_fire_c) begin
            main_d = m_c;
          end else if (in_fire_c) begin
            skid_d = m_c;
          end
        end
        FULL:    if (out_fire_c) main_d = skid_q;
        default: main_d = main_q;
      endcase
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;

endmodule

// File: tb/tb_mux_n_skid.sv
// Self-checking bench: three configurations driven in lockstep against a FIFO reference model.
module tb_mux_n_skid;

  logic clk;
  logic rst;

  mux_n_skid_if #(.W(8), .N(4)) if0 ();
  mux_n_skid_if #(.W(8), .N(3)) if1 ();
  mux_n_skid_if #(.W(8), .N(4)) if2 ();

  mux_n_skid #(.W(8), .N(4), .ONEHOT(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  mux_n_skid #(.W(8), .N(3), .ONEHOT(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
  mux_n_skid #(.W(8), .N(4), .ONEHOT(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference: FIFO contents per configuration, shared occupancy, and the value left on out_data.
  logic [7:0] mq   [3][2];
  logic [7:0] hold [3];
  int         cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_bin(input logic [31:0] d, input int n,
                                         input logic [1:0] s, input logic e);
    if (!e || int'(s) >= n) return 8'h00;
    return 8'(d >> (int'(s) * 8));
  endfunction

  function automatic logic [7:0] ref_oh(input logic [31:0] d, input logic [3:0] soh,
                                        input logic e);
    if (!e) return 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (soh[i]) return 8'(d >> (i * 8));
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_data(input int k);
    return (cnt > 0) ? mq[k][0] : hold[k];
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".valid0"}, 32'(if0.out_valid), 32'(cnt > 0));
    chk({tag, ".valid1"}, 32'(if1.out_valid), 32'(cnt > 0));
    chk({tag, ".valid2"}, 32'(if2.out_valid), 32'(cnt > 0));
    chk({tag, ".ready0"}, 32'(if0.in_ready), 32'(cnt < 2));
    chk({tag, ".ready1"}, 32'(if1.in_ready), 32'(cnt < 2));
    chk({tag, ".ready2"}, 32'(if2.in_ready), 32'(cnt < 2));
    chk({tag, ".data0"}, 32'(if0.out_data), 32'(exp_data(0)));
    chk({tag, ".data1"}, 32'(if1.out_data), 32'(exp_data(1)));
    chk({tag, ".data2"}, 32'(if2.out_data), 32'(exp_data(2)));
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic e,
                       input logic [1:0] s, input logic [3:0] soh, input logic [31:0] d);
    if0.in_valid = iv; if1.in_valid = iv; if2.in_valid = iv;
    if0.out_ready = ordy; if1.out_ready = ordy; if2.out_ready = ordy;
    if0.flush = fl; if1.flush = fl; if2.flush = fl;
    if0.en = e; if1.en = e; if2.en = e;
    if0.sel = s; if1.sel = s; if2.sel = s;
    if0.sel_oh = soh; if1.sel_oh = soh[2:0]; if2.sel_oh = soh;
    if0.in_data = d; if1.in_data = d[23:0]; if2.in_data = d;
  endtask

  task automatic model_clear();
    cnt = 0;
    for (int k = 0; k < 3; k++) hold[k] = 8'h00;
  endtask

  // One clock: drive at negedge, advance the model at posedge, check at the next negedge.
  task automatic step(input string tag, input logic iv, input logic ordy, input logic fl,
                      input logic e, input logic [1:0] s, input logic [3:0] soh,
                      input logic [31:0] d);
    logic       in_acc;
    logic       out_acc;
    logic [7:0] v [3];
    drive(iv, ordy, fl, e, s, soh, d);
    in_acc  = iv && (cnt < 2);
    out_acc = (cnt > 0) && ordy;
    v[0] = ref_bin(d, 4, s, e);
    v[1] = ref_bin({8'h00, d[23:0]}, 3, s, e);
    v[2] = ref_oh(d, soh, e);
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (out_acc) begin
        for (int k = 0; k < 3; k++) mq[k][0] = mq[k][1];
        cnt--;
      end
      if (in_acc) begin
        for (int k = 0; k < 3; k++) mq[k][cnt] = v[k];
        cnt++;
      end
      if (cnt > 0) begin
        for (int k = 0; k < 3; k++) hold[k] = mq[k][0];
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 32'd0);
    model_clear();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // Streaming: sel 0..3 with out_ready high, one result per cycle.
    d = 32'h44332211;
    for (int s = 0; s < 4; s++) begin
      step("stream", 1'b1, 1'b1, 1'b0, 1'b1, 2'(s), 4'(1 << s), d);
      chk("stream.val", 32'(if0.out_data), 32'(8'h11 * (s + 1)));
    end
    chk("oor.n3", 32'(if1.out_data), 32'h0);
    chk("oor.valid", 32'(if1.out_valid), 32'h1);

    // Enable low forces zero but still transfers.
    step("en0", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, d);
    chk("en0.data", 32'(if0.out_data), 32'h0);

    // One-hot: lowest set bit wins; empty select gives zero.
    step("oh", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0110, d);
    chk("oh.0110", 32'(if2.out_data), 32'h22);
    step("oh0", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, d);
    chk("oh.0000", 32'(if2.out_data), 32'h0);
    step("drain", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd0, d);

    // Backpressure: A,B accepted, C held upstream, then released in order.
    step("bp.a", 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 32'h000000A1);
    step("bp.b", 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 32'h000000B2);
    step("bp.c", 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 32'h000000C3);
    chk("bp.stall", 32'(if0.in_ready), 32'h0);
    chk("bp.head", 32'(if0.out_data), 32'hA1);
    step("bp.r1", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 32'h000000C3);
    chk("bp.second", 32'(if0.out_data), 32'hB2);
    step("bp.r2", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 32'h000000C3);
    chk("bp.third", 32'(if0.out_data), 32'hC3);
    step("bp.r3", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 32'h0);

    // Flush in FULL with a same-cycle offer: everything discarded.
    step("fl.a", 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 32'h00550000);
    step("fl.b", 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 32'h00660000);
    step("fl.go", 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 32'h00770000);
    chk("fl.valid", 32'(if0.out_valid), 32'h0);
    chk("fl.ready", 32'(if0.in_ready), 32'h1);
    step("fl.after", 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 32'h0);

    // Asynchronous reset while FULL clears outputs within the same cycle.
    step("rs.a", 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 32'h99000000);
    step("rs.b", 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 32'h88000000);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 32'd0);
    #1 rst = 1'b1;
    #1;
    model_clear();
    check_outputs("rst.mid");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) != 0), 2'($urandom), 4'($urandom), 32'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mux_n_skid.md
# mux_n_skid

Parametrised N-input, W-bit select stage with a valid/ready handshake and a 2-entry skid buffer, used on the TinyRISC pipeline datapath (operand forwarding, writeback source select) where the downstream stage can stall. It generalises the fixed 4:1 enable-gated selector with:
- an arbitrary input count;
- a choice of binary or one-hot select;
- a registered, backpressure-safe output that never drops or duplicates a transfer.

## Interface
Parameters:
- W, 32, data width per input
- N, 4, number of inputs (N ≥ 2)
- ONEHOT, 0, 0 = binary `sel` used, 1 = one-hot `sel_oh` used
- SELW, $clog2(N), derived localparam, not overridable

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  N*W  flattened inputs; input i occupies bits [i*W +: W]
- sel  in  SELW  binary select (ONEHOT=0)
- sel_oh  in  N  one-hot select (ONEHOT=1)
- en  in  1  0 forces the selected value to all-zero
- in_valid  in  1  upstream offers a transfer
- in_ready  out  1  stage can accept a transfer
- flush  in  1  synchronous discard of all held entries
- out_data  out  W  head entry data
- out_valid  out  1  head entry present
- out_ready  in  1  downstream accepts head

## Operation
- Selected value m (combinational):
  - en=0 → 0.
  - ONEHOT=0: in_data[sel]; sel ≥ N → 0.
  - ONEHOT=1: input of the lowest set bit of sel_oh; sel_oh=0 → 0.
- Transfers: input when in_valid && in_ready; output when out_valid && out_ready.
- Storage: main register (drives out_data) plus skid register. State in {EMPTY, ONE, FULL}.
- EMPTY:
  - in accept → m written to main, go ONE.
- ONE:
  - in only → m to skid, go FULL.
  - out only → go EMPTY.
  - in and out together → m to main, stay ONE.
- FULL:
  - out → skid moves to main, go ONE.
  - in_ready=0, so no in accept is possible.
- in_ready = (state != FULL). It is a register-derived signal with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- flush=1 → next state EMPTY, and held data is zeroed.
  - flush has priority over a same-cycle in accept; that input is dropped, and the upstream must treat it as flushed.
  - An output transfer in the flush cycle is still valid (downstream saw the head).
- Data registers update only on accept or shift. Otherwise they hold, even when invalid.

## Timing
- Reset (async assert, sync-safe deassert by the system): state=EMPTY, out_valid=0, out_data=0, in_ready=1, skid=0.
- Reset mid-operation discards all entries at once.
- Latency: an accept at edge k gives out_valid=1 with that data after edge k (visible in cycle k+1).
- Throughput: 1 transfer/cycle in ONE with out_ready held high.
- in_ready falls the cycle after the second unconsumed accept. It rises the cycle after the first out transfer from FULL.
- Ordering is strictly FIFO; the select is sampled only in the cycle of the input accept.

## Structure
- Shared package `tinyrisc_pkg` holds:
  - state typedef `skid_state_t` {EMPTY, ONE, FULL};
  - localparam helper for the SELW computation.
- Sub-module `mux_n` (combinational, parameters W, N, ONEHOT) produces m.
- `mux_n_skid` instantiates `mux_n` and adds the skid-buffer state machine.

## Test plan
- Reset: rst=1 mid-stream while FULL → out_valid=0, out_data=0, in_ready=1 in the same cycle.
- Streaming: N=4, W=8, ONEHOT=0, in_data={8'h44,8'h33,8'h22,8'h11}, sel cycling 0..3, out_ready=1 → out_data 11,22,33,44 at 1-cycle latency, no bubbles.
- Out-of-range and disable: N=3, sel=3 → 0; en=0 with sel=1 → 0; both still complete a valid transfer.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1, values A,B,C offered → A,B accepted, in_ready=0, C held upstream; on release the outputs are A,B,C in order.
- One-hot: ONEHOT=1, sel_oh=4'b0110 → input 1 selected; sel_oh=0 → 0.
- Flush: flush in FULL together with in_valid=1 → next cycle EMPTY, out_valid=0, in_ready=1, offered data never appears.
